imm_ext_pipe: RTL and testbench
===============================

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width; multiple of 8, >= 32.
REQ-002 Parameter IMM_W, default 16: immediate field width, taken from in_data[IMM_W-1:0].
REQ-003 Parameter SHAMT, default 2: left-shift amount for mode SEXT_SH.
REQ-004 Parameter HI_SH, default 16: left-shift amount for mode HIGH.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous pipeline clear.
REQ-008 in_valid  input  1  upstream offers an operand.
REQ-009 in_ready  output  1  block accepts the operand this cycle.
REQ-010 in_data  input  DATA_W  immediate (low IMM_W bits) or raw memory word.
REQ-011 in_mode  input  3  0 SEXT, 1 ZEXT, 2 SEXT_SH, 3 HIGH, 4 LB, 5 LBU, 6 LH, 7 LHU.
REQ-012 in_off  input  OFF_W=clog2(DATA_W/8)  byte offset for modes 4-7.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream takes result this cycle.
REQ-015 out_data  output  DATA_W  extended result.
REQ-016 out_err  output  1  result flagged misaligned.

Function
REQ-017 Transfer occurs only when valid and ready are both 1 on the same edge, per port.
REQ-018 Two registered stages: S1 captures in_data/in_mode/in_off; S2 holds the computed result; minimum latency 2 cycles from input transfer to out_valid=1.
REQ-019 Throughput of one result per cycle while out_ready=1.
REQ-020 Advance rule: S2 loads when !v2 or out_ready; S1 loads when !v1 or S2 loads; in_ready = !v1 or S2 loads (combinational).
REQ-021 While out_valid=1 and out_ready=0, out_data and out_err hold stable.
REQ-022 SEXT: sign-extend imm to DATA_W; ZEXT: zero-extend.
REQ-023 SEXT_SH: sign-extended imm shifted left SHAMT, truncated to DATA_W.
REQ-024 HIGH: sign-extended imm shifted left HI_SH, truncated to DATA_W.
REQ-025 LB/LBU: byte in_data[8*off+7:8*off], sign/zero-extended.
REQ-026 LH/LHU: halfword starting at byte off, sign/zero-extended; off[0]=1 gives out_data=0, out_err=1.
REQ-027 out_err=0 for all other modes and aligned halfwords.
REQ-028 flush=1 clears v1 and v2 on that edge; an input offered in the same cycle is dropped; flush beats simultaneous transfers.
REQ-029 in_ready reports 1 during flush; dropped input is not retried.

Reset
REQ-030 reset=1 asynchronously clears v1, v2, out_valid, out_data, out_err to 0; in_ready reads 1 while reset is asserted.
REQ-031 Reset mid-transfer discards all in-flight operands; first valid output after release requires a fresh input and 2 cycles.

Verification
REQ-032 Mode 0, in_data=0x0000_8001, out_ready=1 -> out_data=0xFFFF_8001 exactly 2 cycles after transfer.
REQ-033 Modes 1,2,3 with imm 0x8001 -> 0x0000_8001, 0xFFFE_0004, 0x8001_0000.
REQ-034 in_data=0x80FF_7F01, LB off=3 -> 0xFFFF_FF80; LBU off=1 -> 0x0000_007F; LH off=2 -> 0xFFFF_80FF; LHU off=1 -> 0, out_err=1.
REQ-035 Stream 4 operands, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, out_data held, all 4 emerge in order once out_ready=1.
REQ-036 flush asserted with v1=v2=1 and in_valid=1 -> next cycle out_valid=0, no stale result ever appears.
REQ-037 reset pulsed between edges with pipeline full -> out_valid=0 immediately, no output until new input.

Source files
------------

// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: input/output handshake channels for the immediate-extension pipeline
// in_*  : upstream operand channel (valid/ready, raw data, mode, byte offset)
// out_* : downstream result channel (valid/ready, extended data, misalignment flag)
interface imm_ext_pipe_if #(
  parameter int DATA_W = 32,
  parameter int OFF_W = $clog2(DATA_W / 8)
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0] in_mode;
  logic [OFF_W-1:0] in_off;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic out_err;
  modport master (
    output in_valid, in_data, in_mode, in_off, out_ready,
    input in_ready, out_valid, out_data, out_err
  );
  modport slave (
    input in_valid, in_data, in_mode, in_off, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage immediate / load-data sign/zero extension pipeline
// clk   : rising-edge clock
// reset : asynchronous active-high reset, empties the pipeline
// flush : synchronous clear of both stages, drops any operand offered that cycle
// bus   : slave side of imm_ext_pipe_if (in_* operand channel, out_* result channel)
module imm_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W = 16,
  parameter int SHAMT = 2,
  parameter int HI_SH = 16
) (
  input logic clk,
  input logic reset,
  input logic flush,
  imm_ext_pipe_if.slave bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  logic v1, v2, ld1, ld2, err;
  logic [DATA_W-1:0] d1, sext, zext, res;
  logic [2:0] m1;
  logic [OFF_W-1:0] o1;
  logic [IMM_W-1:0] imm;
  logic [7:0] b;
  logic [15:0] h;
  assign ld2 = !v2 || bus.out_ready;
  assign ld1 = !v1 || ld2;
  // flush always swallows the offered operand, so it reads as accepted
  assign bus.in_ready = ld1 || flush;
  assign bus.out_valid = v2;
  always_comb begin
    imm = d1[IMM_W-1:0];
    sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    b = d1[8*o1 +: 8];
    // halfword index drops off[0] so the select stays in range; odd offsets are flagged below
    h = d1[16*o1[OFF_W-1:1] +: 16];
    err = m1[2] && m1[1] && o1[0];
    res = err ? '0 :
          m1 == 3'd0 ? sext :
          m1 == 3'd1 ? zext :
          m1 == 3'd2 ? sext << SHAMT :
          m1 == 3'd3 ? sext << HI_SH :
          m1 == 3'd4 ? {{(DATA_W-8){b[7]}}, b} :
          m1 == 3'd5 ? {{(DATA_W-8){1'b0}}, b} :
          m1 == 3'd6 ? {{(DATA_W-16){h[15]}}, h} :
                       {{(DATA_W-16){1'b0}}, h};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      m1 <= '0;
      o1 <= '0;
      bus.out_data <= '0;
      bus.out_err <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (ld1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          d1 <= bus.in_data;
          m1 <= bus.in_mode;
          o1 <= bus.in_off;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          bus.out_data <= res;
          bus.out_err <= err;
        end
      end
    end
  end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed vector bench for imm_ext_pipe
module tb_imm_ext_pipe;
  typedef struct {
    logic [2:0] mode;
    logic [1:0] off;
    logic [31:0] data;
    logic [31:0] exp;
    logic err;
  } vec_t;
  localparam int NV = 15;
  logic clk = 1'b0;
  logic reset, flush;
  int n_chk = 0;
  int n_fail = 0;
  vec_t v[NV];
  imm_ext_pipe_if #(.DATA_W(32)) bus();
  imm_ext_pipe dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(int i);
    bus.in_valid = 1'b1;
    bus.in_mode = v[i].mode;
    bus.in_off = v[i].off;
    bus.in_data = v[i].data;
  endtask
  task automatic fill_two();
    bus.out_ready = 1'b0;
    drive(0);
    @(negedge clk);
    drive(1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("full_ov", 32'(bus.out_valid), 32'd1);
    chk("full_ir", 32'(bus.in_ready), 32'd0);
  endtask
  initial begin
    logic rdy, ov;
    logic [31:0] od;
    int ii, oo;
    v[0] = '{3'd0, 2'd0, 32'h0000_8001, 32'hFFFF_8001, 1'b0};
    v[1] = '{3'd1, 2'd0, 32'h0000_8001, 32'h0000_8001, 1'b0};
    v[2] = '{3'd2, 2'd0, 32'h0000_8001, 32'hFFFE_0004, 1'b0};
    v[3] = '{3'd3, 2'd0, 32'h0000_8001, 32'h8001_0000, 1'b0};
    v[4] = '{3'd4, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0};
    v[5] = '{3'd5, 2'd1, 32'h80FF_7F01, 32'h0000_007F, 1'b0};
    v[6] = '{3'd6, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0};
    v[7] = '{3'd7, 2'd1, 32'h80FF_7F01, 32'h0000_0000, 1'b1};
    v[8] = '{3'd6, 2'd0, 32'h80FF_7F01, 32'h0000_7F01, 1'b0};
    v[9] = '{3'd7, 2'd2, 32'h80FF_7F01, 32'h0000_80FF, 1'b0};
    v[10] = '{3'd4, 2'd0, 32'h80FF_7F01, 32'h0000_0001, 1'b0};
    v[11] = '{3'd6, 2'd3, 32'h80FF_7F01, 32'h0000_0000, 1'b1};
    v[12] = '{3'd0, 2'd0, 32'h1234_7FFF, 32'h0000_7FFF, 1'b0};
    v[13] = '{3'd3, 2'd0, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
    v[14] = '{3'd5, 2'd3, 32'h80FF_7F01, 32'h0000_0080, 1'b0};
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_mode = '0;
    bus.in_off = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_od", bus.out_data, 32'd0);
    chk("rst_oe", 32'(bus.out_err), 32'd0);
    chk("rst_ir", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // isolated transfers: result appears exactly two cycles after being offered
    for (int i = 0; i < NV; i++) begin
      drive(i);
      #1;
      chk($sformatf("v%0d_ir", i), 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_early", i), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_ov", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_od", i), bus.out_data, v[i].exp);
      chk($sformatf("v%0d_oe", i), 32'(bus.out_err), 32'(v[i].err));
    end
    @(negedge clk);
    // back-to-back stream at full throughput
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) drive(i);
      else bus.in_valid = 1'b0;
      if (i >= 2) begin
        chk($sformatf("s%0d_ov", i - 2), 32'(bus.out_valid), 32'd1);
        chk($sformatf("s%0d_od", i - 2), bus.out_data, v[i-2].exp);
        chk($sformatf("s%0d_oe", i - 2), 32'(bus.out_err), 32'(v[i-2].err));
      end
      @(negedge clk);
    end
    chk("s_drained", 32'(bus.out_valid), 32'd0);
    // backpressure: four operands, downstream stalled early on
    ii = 0;
    oo = 0;
    for (int c = 0; c < 30 && oo < 4; c++) begin
      bus.out_ready = (c >= 5);
      if (ii < 4) drive(ii);
      else bus.in_valid = 1'b0;
      #1;
      rdy = bus.in_ready;
      ov = bus.out_valid;
      od = bus.out_data;
      if (c >= 2 && c <= 4) begin
        chk($sformatf("bp%0d_ir", c), 32'(rdy), 32'd0);
        chk($sformatf("bp%0d_hold", c), od, v[0].exp);
      end
      if (c == 5) chk("bp_accepted", ii, 2);
      @(posedge clk);
      if (rdy && bus.in_valid) ii++;
      if (ov && bus.out_ready) begin
        chk($sformatf("bp_out%0d", oo), od, v[oo].exp);
        oo++;
      end
      @(negedge clk);
    end
    chk("bp_count", oo, 4);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    // flush with both stages full and a new operand offered
    fill_two();
    flush = 1'b1;
    drive(2);
    #1;
    chk("fl_ir", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("fl_ov%0d", c), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    // asynchronous reset pulse between edges with the pipeline full
    fill_two();
    #1;
    reset = 1'b1;
    #1;
    chk("ar_ov", 32'(bus.out_valid), 32'd0);
    chk("ar_od", bus.out_data, 32'd0);
    chk("ar_oe", 32'(bus.out_err), 32'd0);
    chk("ar_ir", 32'(bus.in_ready), 32'd1);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ar_idle%0d", c), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    drive(6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ar_new_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("ar_new_ov", 32'(bus.out_valid), 32'd1);
    chk("ar_new_od", bus.out_data, v[6].exp);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
